// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : alu_issue_stage_if
// Brief   : Bundles the ID-side, EX-side and ALU-control signals of the
//           ALU issue register.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface alu_issue_stage_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int CNT_WIDTH      = 8,
   parameter int LOGIC_OP_WIDTH = 3
);
   logic                      valid_i;
   logic                      ready_o;
   logic [5:0]                opcode_i;
   logic [5:0]                funct_i;
   logic [4:0]                shamt_i;
   logic [15:0]               imm_i;
   logic [DATA_WIDTH-1:0]     rs_data_i;
   logic [DATA_WIDTH-1:0]     rt_data_i;
   logic                      ex_stall_i;
   logic                      flush_i;
   logic                      valid_o;
   logic [LOGIC_OP_WIDTH-1:0] logic_op_o;
   logic                      sub_o;
   logic                      arithlogic_o;
   logic                      slt_sel_o;
   logic [DATA_WIDTH-1:0]     opd1_o;
   logic [DATA_WIDTH-1:0]     opd2_o;
   logic                      illegal_o;
   logic [CNT_WIDTH-1:0]      illegal_cnt_o;

   modport slave (
      input  valid_i, opcode_i, funct_i, shamt_i, imm_i, rs_data_i, rt_data_i,
             ex_stall_i, flush_i,
      output ready_o, valid_o, logic_op_o, sub_o, arithlogic_o, slt_sel_o,
             opd1_o, opd2_o, illegal_o, illegal_cnt_o
   );

   modport master (
      output valid_i, opcode_i, funct_i, shamt_i, imm_i, rs_data_i, rt_data_i,
             ex_stall_i, flush_i,
      input  ready_o, valid_o, logic_op_o, sub_o, arithlogic_o, slt_sel_o,
             opd1_o, opd2_o, illegal_o, illegal_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : alu_issue_stage
// Brief   : ID/EX issue register: decodes MIPS opcode/funct into ALU control
//           and operands, with valid/ready backpressure, flush and an
//           illegal-instruction counter.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8
) (
   input  wire               clk,
   input  wire               rst_n,
   alu_issue_stage_if.slave  bus
);
   // logic_op encoding shared with the ALU
   localparam logic [2:0] LOGIC_AND = 3'd0;
   localparam logic [2:0] LOGIC_OR  = 3'd1;
   localparam logic [2:0] LOGIC_XOR = 3'd2;
   localparam logic [2:0] LOGIC_SLL = 3'd4;
   localparam logic [2:0] LOGIC_SRL = 3'd5;
   localparam logic [2:0] LOGIC_SRA = 3'd6;

   logic [DATA_WIDTH-1:0] w_sext, w_zext, w_shamt;
   logic                  w_illegal, w_arith, w_sub, w_slt;
   logic [2:0]            w_lop;
   logic [DATA_WIDTH-1:0] w_opd1, w_opd2;

   logic                  valid_q, valid_d;
   logic                  illegal_q, illegal_d;
   logic                  arith_q, arith_d;
   logic                  sub_q, sub_d;
   logic                  slt_q, slt_d;
   logic [2:0]            lop_q, lop_d;
   logic [DATA_WIDTH-1:0] opd1_q, opd1_d, opd2_q, opd2_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  w_ready, w_accept;

   assign w_sext  = {{(DATA_WIDTH-16){bus.imm_i[15]}}, bus.imm_i};
   assign w_zext  = {{(DATA_WIDTH-16){1'b0}}, bus.imm_i};
   assign w_shamt = {{(DATA_WIDTH-5){1'b0}}, bus.shamt_i};

   always_comb begin
      w_illegal = 1'b0;
      w_arith   = 1'b1;
      w_sub     = 1'b0;
      w_slt     = 1'b0;
      w_lop     = LOGIC_AND;
      w_opd1    = bus.rs_data_i;
      w_opd2    = bus.rt_data_i;
      case (bus.opcode_i)
         6'h00: begin
            case (bus.funct_i)
               6'h20, 6'h21: ;
               6'h22, 6'h23: w_sub = 1'b1;
               6'h2A: begin w_sub = 1'b1; w_slt = 1'b1; end
               6'h24: w_arith = 1'b0;
               6'h25: begin w_arith = 1'b0; w_lop = LOGIC_OR;  end
               6'h26: begin w_arith = 1'b0; w_lop = LOGIC_XOR; end
               6'h00: begin w_arith = 1'b0; w_lop = LOGIC_SLL; w_opd1 = bus.rt_data_i; w_opd2 = w_shamt; end
               6'h02: begin w_arith = 1'b0; w_lop = LOGIC_SRL; w_opd1 = bus.rt_data_i; w_opd2 = w_shamt; end
               6'h03: begin w_arith = 1'b0; w_lop = LOGIC_SRA; w_opd1 = bus.rt_data_i; w_opd2 = w_shamt; end
               // variable shifts pass rs unmasked; the ALU only looks at [4:0]
               6'h04: begin w_arith = 1'b0; w_lop = LOGIC_SLL; w_opd1 = bus.rt_data_i; w_opd2 = bus.rs_data_i; end
               6'h06: begin w_arith = 1'b0; w_lop = LOGIC_SRL; w_opd1 = bus.rt_data_i; w_opd2 = bus.rs_data_i; end
               6'h07: begin w_arith = 1'b0; w_lop = LOGIC_SRA; w_opd1 = bus.rt_data_i; w_opd2 = bus.rs_data_i; end
               default: w_illegal = 1'b1;
            endcase
         end
         6'h08, 6'h09, 6'h23, 6'h2B: w_opd2 = w_sext;
         6'h0A: begin w_sub = 1'b1; w_slt = 1'b1; w_opd2 = w_sext; end
         6'h04, 6'h05: w_sub = 1'b1;
         6'h0C: begin w_arith = 1'b0; w_opd2 = w_zext; end
         6'h0D: begin w_arith = 1'b0; w_lop = LOGIC_OR;  w_opd2 = w_zext; end
         6'h0E: begin w_arith = 1'b0; w_lop = LOGIC_XOR; w_opd2 = w_zext; end
         6'h0F: begin w_arith = 1'b0; w_lop = LOGIC_SLL; w_opd1 = w_zext; w_opd2 = DATA_WIDTH'(16); end
         default: w_illegal = 1'b1;
      endcase
      if (w_illegal) begin
         w_arith = 1'b1;
         w_sub   = 1'b0;
         w_slt   = 1'b0;
         w_lop   = LOGIC_AND;
         w_opd1  = '0;
         w_opd2  = '0;
      end
   end

   assign w_ready  = !valid_q || !bus.ex_stall_i;
   assign w_accept = bus.valid_i && w_ready && !bus.flush_i;

   always_comb begin
      valid_d   = valid_q;
      illegal_d = illegal_q;
      arith_d   = arith_q;
      sub_d     = sub_q;
      slt_d     = slt_q;
      lop_d     = lop_q;
      opd1_d    = opd1_q;
      opd2_d    = opd2_q;
      cnt_d     = cnt_q;
      if (bus.flush_i) begin
         valid_d   = 1'b0;
         illegal_d = 1'b0;
      end else if (w_accept) begin
         valid_d   = 1'b1;
         illegal_d = w_illegal;
         arith_d   = w_arith;
         sub_d     = w_sub;
         slt_d     = w_slt;
         lop_d     = w_lop;
         opd1_d    = w_opd1;
         opd2_d    = w_opd2;
         if (w_illegal && (cnt_q != {CNT_WIDTH{1'b1}}))
            cnt_d = cnt_q + 1'b1;
      end else if (valid_q && !bus.ex_stall_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         arith_q   <= 1'b0;
         sub_q     <= 1'b0;
         slt_q     <= 1'b0;
         lop_q     <= '0;
         opd1_q    <= '0;
         opd2_q    <= '0;
         cnt_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         arith_q   <= arith_d;
         sub_q     <= sub_d;
         slt_q     <= slt_d;
         lop_q     <= lop_d;
         opd1_q    <= opd1_d;
         opd2_q    <= opd2_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.ready_o       = w_ready;
   assign bus.valid_o       = valid_q;
   assign bus.illegal_o     = illegal_q;
   assign bus.arithlogic_o  = arith_q;
   assign bus.sub_o         = sub_q;
   assign bus.slt_sel_o     = slt_q;
   assign bus.logic_op_o    = lop_q;
   assign bus.opd1_o        = opd1_q;
   assign bus.opd2_o        = opd2_q;
   assign bus.illegal_cnt_o = cnt_q;
endmodule
`default_nettype wire
